// File: rtl/tone_arbiter.sv
// tone_arbiter
//   Shares one audio tone generator between two players. Each hit queues a
//   three-step jingle (up to three per player); queued jingles are played one
//   at a time, separated by a silent gap, with round-robin on ties.
//
// Ports
//   CLK      in   1   system clock
//   RESET_N  in   1   asynchronous active-low reset
//   HIT1     in   1   player-1 hit pulse
//   HIT2     in   1   player-2 hit pulse
//   FREQ     out  32  tone frequency in Hz, 0 = silent (registered)
//   GRANT    out  2   one-hot jingle owner, bit0 = player 1 (registered)
//   BUSY     out  1   high while playing or in the gap
//   DONE     out  1   one-cycle pulse as the last step ends (registered)
//   DROP1/2  out  1   one-cycle pulse when a hit is lost to saturation (registered)
module tone_arbiter #(
  parameter int unsigned STEP_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 1000000,
  parameter logic [31:0] TONE_LO     = 32'd523,
  parameter logic [31:0] TONE_MID    = 32'd659,
  parameter logic [31:0] TONE_HI     = 32'd784
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        HIT1,
  input  logic        HIT2,
  output logic [31:0] FREQ,
  output logic [1:0]  GRANT,
  output logic        BUSY,
  output logic        DONE,
  output logic        DROP1,
  output logic        DROP2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  pend1_q, pend1_d;
  logic [1:0]  pend2_q, pend2_d;
  logic        last_q, last_d;      // 1 = player 2 was granted last
  logic [31:0] freq_d;
  logic [1:0]  grant_d;
  logic        done_d, drop1_d, drop2_d;
  logic        gnt1, gnt2;

  // Player 1 ascends, player 2 descends through the same three tones.
  function automatic logic [31:0] tone_for(input logic p2, input logic [1:0] step);
    logic [1:0] idx;
    idx = p2 ? (2'd2 - step) : step;
    case (idx)
      2'd0:    tone_for = TONE_LO;
      2'd1:    tone_for = TONE_MID;
      2'd2:    tone_for = TONE_HI;
      default: tone_for = '0;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      pend1_q <= '0;
      pend2_q <= '0;
      last_q  <= 1'b1;
      FREQ    <= '0;
      GRANT   <= '0;
      DONE    <= 1'b0;
      DROP1   <= 1'b0;
      DROP2   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      last_q  <= last_d;
      FREQ    <= freq_d;
      GRANT   <= grant_d;
      DONE    <= done_d;
      DROP1   <= drop1_d;
      DROP2   <= drop2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    last_d  = last_q;
    freq_d  = FREQ;
    grant_d = GRANT;
    done_d  = 1'b0;
    gnt1    = 1'b0;
    gnt2    = 1'b0;

    case (state_q)
      IDLE: begin
        // Player 1 wins a tie only if player 2 had the previous grant.
        if (pend1_q != 2'd0 && (pend2_q == 2'd0 || last_q)) begin
          gnt1 = 1'b1;
        end else if (pend2_q != 2'd0) begin
          gnt2 = 1'b1;
        end
        if (gnt1 || gnt2) begin
          state_d = PLAY;
          step_d  = '0;
          cnt_d   = '0;
          last_d  = gnt2;
          grant_d = {gnt2, gnt1};
          freq_d  = tone_for(gnt2, 2'd0);
        end
      end
      PLAY: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (step_q == 2'd2) begin
            state_d = GAP;
            freq_d  = '0;
            grant_d = '0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            freq_d = tone_for(GRANT[1], step_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A hit coinciding with this player's grant cancels the decrement.
  always_comb begin
    pend1_d = pend1_q;
    drop1_d = 1'b0;
    if (HIT1 && !gnt1) begin
      if (pend1_q == 2'd3) drop1_d = 1'b1;
      else                 pend1_d = pend1_q + 2'd1;
    end else if (!HIT1 && gnt1) begin
      pend1_d = pend1_q - 2'd1;
    end
  end

  always_comb begin
    pend2_d = pend2_q;
    drop2_d = 1'b0;
    if (HIT2 && !gnt2) begin
      if (pend2_q == 2'd3) drop2_d = 1'b1;
      else                 pend2_d = pend2_q + 2'd1;
    end else if (!HIT2 && gnt2) begin
      pend2_d = pend2_q - 2'd1;
    end
  end

  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_tone_arbiter.sv
// Testbench for tone_arbiter: directed scenarios plus a randomized run, all
// checked every cycle against a time-based behavioural model.
module tb_tone_arbiter;

  localparam int S = 4;
  localparam int G = 2;
  localparam int TONES [3] = '{523, 659, 784};

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        HIT1 = 1'b0;
  logic        HIT2 = 1'b0;
  logic [31:0] FREQ;
  logic [1:0]  GRANT;
  logic        BUSY, DONE, DROP1, DROP2;

  tone_arbiter #(.STEP_CYCLES(S), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HIT1(HIT1), .HIT2(HIT2),
    .FREQ(FREQ), .GRANT(GRANT), .BUSY(BUSY), .DONE(DONE),
    .DROP1(DROP1), .DROP2(DROP2)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: pending counts, and the active jingle as owner + cycles since grant.
  int m_pend [2];
  int m_last;
  bit m_active;
  int m_owner;
  int m_t;
  bit m_drop [2];

  // Statistics gathered from the DUT for the literal scenario checks.
  int busy_cnt, done_cnt, drop2_cnt;
  int own [$];
  logic [1:0] prev_grant;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tone_of(input int owner, input int idx);
    return (owner == 1) ? TONES[idx] : TONES[2 - idx];
  endfunction

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_last = 2;
    m_active = 0; m_owner = 0; m_t = 0;
    m_drop[0] = 0; m_drop[1] = 0;
  endtask

  task automatic model_step(input bit h1, input bit h2);
    int gnt_to;
    bit h [2];
    bit dec;
    h[0] = h1; h[1] = h2;
    gnt_to = 0;
    if (!m_active) begin
      if (m_pend[0] > 0 && (m_pend[1] == 0 || m_last == 2)) gnt_to = 1;
      else if (m_pend[1] > 0) gnt_to = 2;
      if (gnt_to != 0) begin
        m_active = 1; m_t = 0; m_owner = gnt_to; m_last = gnt_to;
      end
    end else begin
      m_t++;
      if (m_t == 3 * S + G) m_active = 0;
    end
    for (int x = 0; x < 2; x++) begin
      dec = (gnt_to == x + 1);
      m_drop[x] = 0;
      if (h[x]) begin
        if (!dec) begin
          if (m_pend[x] == 3) m_drop[x] = 1;
          else m_pend[x]++;
        end
      end else if (dec) begin
        m_pend[x]--;
      end
    end
  endtask

  task automatic compare();
    bit play;
    int ef, eg;
    play = m_active && (m_t < 3 * S);
    ef = play ? tone_of(m_owner, m_t / S) : 0;
    eg = play ? ((m_owner == 1) ? 1 : 2) : 0;
    chk("freq", FREQ, ef);
    chk("grant", GRANT, eg);
    chk("busy", BUSY, m_active);
    chk("done", DONE, m_active && (m_t == 3 * S));
    chk("drop1", DROP1, m_drop[0]);
    chk("drop2", DROP2, m_drop[1]);
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; drop2_cnt = 0;
    own.delete();
  endtask

  // Drive hits at the falling edge, update the model on the rising edge,
  // compare at the next falling edge.
  task automatic tick(input bit h1, input bit h2);
    HIT1 = h1; HIT2 = h2;
    @(posedge CLK);
    model_step(h1, h2);
    @(negedge CLK);
    HIT1 = 1'b0; HIT2 = 1'b0;
    compare();
    busy_cnt += int'(BUSY);
    done_cnt += int'(DONE);
    drop2_cnt += int'(DROP2);
    if (GRANT != 2'b00 && prev_grant == 2'b00) own.push_back(GRANT == 2'b01 ? 1 : 2);
    prev_grant = GRANT;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; HIT1 = 1'b0; HIT2 = 1'b0;
    model_reset();
    prev_grant = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_freq", FREQ, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_drops", {DROP1, DROP2}, 0);
    RESET_N = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_stats();
    prev_grant = 2'b00;

    // Single player-1 jingle from idle.
    do_reset();
    tick(1'b1, 1'b0);
    chk("s34_freq_before_grant", FREQ, 0);
    clear_stats();
    tick(1'b0, 1'b0);
    chk("s34_first_freq", FREQ, 523);
    chk("s34_first_grant", GRANT, 1);
    idle(19);
    chk("s34_busy_cycles", busy_cnt, 14);
    chk("s34_done_pulses", done_cnt, 1);

    // Simultaneous first hits: player 1 first, then player 2.
    do_reset();
    clear_stats();
    tick(1'b1, 1'b1);
    idle(40);
    chk("s35_n_jingles", own.size(), 2);
    chk("s35_owner0", own[0], 1);
    chk("s35_owner1", own[1], 2);
    chk("s35_done_pulses", done_cnt, 2);

    // Five player-2 hits during a player-1 jingle: two are dropped.
    do_reset();
    clear_stats();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
    idle(70);
    chk("s36_drop2_pulses", drop2_cnt, 2);
    chk("s36_n_jingles", own.size(), 4);
    chk("s36_owner0", own[0], 1);
    chk("s36_owner3", own[3], 2);

    // Hit coinciding with the grant decrement: a second jingle still plays.
    do_reset();
    clear_stats();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    idle(40);
    chk("s37_n_jingles", own.size(), 2);
    chk("s37_drop2_pulses", drop2_cnt, 0);

    // Reset during step 1 with a queued player-2 jingle.
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    idle(5);
    chk("s38_step1_freq", FREQ, 659);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("s38_async_freq", FREQ, 0);
    chk("s38_async_grant", GRANT, 0);
    chk("s38_async_busy", BUSY, 0);
    do_reset();
    clear_stats();
    idle(40);
    chk("s38_no_jingle", own.size(), 0);

    // Both players saturated: strict alternation, six jingles.
    do_reset();
    clear_stats();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    idle(110);
    chk("s39_done_pulses", done_cnt, 6);
    chk("s39_n_jingles", own.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("s39_owner%0d", i), own[i], (i % 2 == 0) ? 1 : 2);
    chk("s39_idle_at_end", BUSY, 0);

    // Randomized traffic with one mid-run reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter STEP_CYCLES, default 5000000, clock cycles each tone step is held (>=1).
REQ-002 Parameter GAP_CYCLES, default 1000000, silent cycles between jingles (>=1).
REQ-003 Parameter TONE_LO / TONE_MID / TONE_HI, defaults 523 / 659 / 784, tone frequency codes in Hz.
REQ-004 CLK  input  1  system clock (50 MHz); sole clock of the block.
REQ-005 RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 HIT1  input  1  player-1 hit pulse; one CLK cycle wide; synchronous to CLK.
REQ-007 HIT2  input  1  player-2 hit pulse; one CLK cycle wide; synchronous to CLK.
REQ-008 FREQ  output  32  tone frequency for the shared audio generator; 0 = silent.
REQ-009 GRANT  output  2  one-hot owner of the current jingle: bit0 = player 1, bit1 = player 2; 0 when no jingle plays.
REQ-010 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-011 DONE  output  1  one-cycle pulse when a jingle's last step ends.
REQ-012 DROP1 / DROP2  output  1 each  one-cycle pulse when a player's hit is discarded on saturation.

Function
REQ-013 The block SHALL hold a 2-bit pending count per player (PEND1, PEND2), range 0..3.
REQ-014 HITx with PENDx<3 and no grant-decrement of PENDx in that cycle SHALL increment PENDx.
REQ-015 HITx with PENDx==3 SHALL leave PENDx at 3 and pulse DROPx on the following cycle.
REQ-016 HITx in the same cycle as a grant-decrement of PENDx SHALL leave PENDx unchanged (net zero), and no DROPx SHALL be generated.
REQ-017 FSM states SHALL be IDLE, PLAY and GAP; reset state is IDLE.
REQ-018 IDLE with exactly one PENDx>0: grant that player, decrement PENDx, step=0, cycle counter=0, go to PLAY.
REQ-019 IDLE with both PEND>0: grant the player not granted last (LAST register, reset value = player 2, so player 1 wins the first tie).
REQ-020 LAST SHALL update on every grant.
REQ-021 PLAY SHALL run steps 0, 1, 2, each exactly STEP_CYCLES cycles.
REQ-022 Player-1 jingle: FREQ = TONE_LO, TONE_MID, TONE_HI in steps 0..2.
REQ-023 Player-2 jingle: FREQ = TONE_HI, TONE_MID, TONE_LO in steps 0..2.
REQ-024 When step 2 ends, the FSM SHALL enter GAP and, in that same transition, set FREQ=0, GRANT=0 and pulse DONE for one cycle.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.
REQ-026 Hits arriving during PLAY/GAP SHALL only accumulate in PEND; a jingle in progress is never preempted or restarted.
REQ-027 Latency, idle case: HITx sampled at edge N -> PENDx nonzero after N; grant at edge N+1; FREQ nonzero and GRANT set after edge N+1.
REQ-028 BUSY SHALL be 0 in IDLE and 1 in PLAY and GAP.
REQ-029 FREQ, GRANT, DONE and DROPx SHALL be registered outputs.
REQ-030 The cycle counter SHALL be 32 bits and reset to 0 at each step/state boundary; no wrap-around within legal parameter values.

Reset
REQ-031 RESET_N low SHALL immediately, without a clock, set state=IDLE, PEND1=PEND2=0, LAST=player 2, counter=0, FREQ=0, GRANT=0, BUSY=0, DONE=0, DROP1=DROP2=0.
REQ-032 Reset asserted mid-PLAY or mid-GAP SHALL abort the jingle and discard all pending hits.
REQ-033 Hits present during the first edge after RESET_N rises SHALL be counted normally.

Verification (STEP_CYCLES=4, GAP_CYCLES=2)
REQ-034 Single HIT1 from idle -> GRANT=01; FREQ 523x4, 659x4, 784x4 cycles; DONE pulse; FREQ=0 for 2 cycles; BUSY falls; total BUSY = 14 cycles.
REQ-035 HIT1 and HIT2 in the same cycle after reset -> player-1 jingle 523/659/784, gap, then player-2 jingle 784/659/523, with GRANT 01 then 10.
REQ-036 During a player-1 jingle, 5 HIT2 pulses on separate cycles -> PEND2=3, DROP2 pulses exactly twice, then 3 back-to-back player-2 jingles separated by gaps.
REQ-037 HIT2 in the same cycle PEND2 is decremented by a grant -> PEND2 unchanged, no DROP2.
REQ-038 RESET_N low during step 1 of PLAY -> FREQ=0, GRANT=0, BUSY=0 without a clock edge; a queued jingle never plays after release.
REQ-039 Both PEND held at 3 -> jingle owners alternate 1,2,1,2,1,2; six DONE pulses; then IDLE.
